// File: rtl/clock_sequencer.sv
// clock_sequencer: CPU clock-enable sequencer.
//   Debounces the mode/step buttons and selects MANUAL/SLOW/FAST/MAX rate.
//   Emits a one-cycle clock enable to the CPU.
//   Supports halt-and-single-step when the CPU raises iHalt.
// Ports:
//   iClock        system clock, all logic on posedge
//   iReset        synchronous active-high reset
//   iModeButton   raw async mode button (active-high)
//   iStepButton   raw async step button (active-high)
//   iHalt         CPU halt request (synchronous)
//   iLimit[7:0]   rate divider setting (synchronous)
//   oClockEnable  one-cycle CPU clock-enable pulse
//   oMode[1:0]    00 MANUAL, 01 SLOW, 10 FAST, 11 MAX
//   oHalted       high while halted
//   oCycleCount   saturating count of issued pulses
module clock_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned SLOW_SHIFT      = 16,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iModeButton,
  input  logic                   iStepButton,
  input  logic                   iHalt,
  input  logic [7:0]             iLimit,
  output logic                   oClockEnable,
  output logic [1:0]             oMode,
  output logic                   oHalted,
  output logic [COUNT_WIDTH-1:0] oCycleCount
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DivW = 8 + SLOW_SHIFT + 1;

  localparam logic [1:0] ModeManual = 2'b00;
  localparam logic [1:0] ModeSlow   = 2'b01;
  localparam logic [1:0] ModeFast   = 2'b10;

  typedef enum logic {StRun, StHalted} state_e;

  // Button index 0 = mode, 1 = step.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][DbW-1:0]         db_cnt_q, db_cnt_d;
  logic [1:0]                  level_q, level_d;
  logic [1:0]                  event_q, event_d;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [DivW-1:0]        div_q, div_d;
  logic                   ce_q, ce_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   halt_prev_q;
  logic [7:0]             limit_prev_q;

  logic            mode_ev, step_ev, halt_rise, limit_change;
  logic [DivW-1:0] period_m1;

  assign raw = {iStepButton, iModeButton};

  // Synchronizer plus debounce: the accepted level flips only after the synced
  // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      sync_d[b]   = {sync_q[b][SYNC_STAGES-2:0], raw[b]};
      level_d[b]  = level_q[b];
      event_d[b]  = 1'b0;
      db_cnt_d[b] = '0;
      if (sync_q[b][SYNC_STAGES-1] != level_q[b]) begin
        if (db_cnt_q[b] == DbW'(DEBOUNCE_CYCLES)) begin
          level_d[b] = ~level_q[b];
          event_d[b] = ~level_q[b];  // press only; release never fires
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
        end
      end
    end
  end

  assign mode_ev      = event_q[0];
  assign step_ev      = event_q[1];
  assign halt_rise    = iHalt & ~halt_prev_q;
  assign limit_change = (iLimit != limit_prev_q);

  // Divider terminal value is P-1; the divider width covers the largest SLOW period.
  always_comb begin
    if (mode_q == ModeSlow) begin
      period_m1 = ((DivW'(iLimit) + DivW'(1)) << SLOW_SHIFT) - DivW'(1);
    end else begin
      period_m1 = DivW'(iLimit);
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    ce_d    = 1'b0;
    case (state_q)
      StRun: begin
        if (mode_ev) begin
          mode_d = mode_q + 2'd1;
          div_d  = '0;
        end else if (halt_rise) begin
          state_d = StHalted;
        end else if (limit_change) begin
          div_d = '0;
        end else begin
          case (mode_q)
            ModeManual: ce_d = step_ev;
            ModeSlow, ModeFast: begin
              if (div_q == period_m1) begin
                ce_d  = 1'b1;
                div_d = '0;
              end else begin
                div_d = div_q + DivW'(1);
              end
            end
            default: ce_d = 1'b1;
          endcase
        end
      end
      StHalted: begin
        if (mode_ev) begin
          state_d = StRun;
          div_d   = '0;
        end else if (step_ev) begin
          ce_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (ce_d && !(&count_q)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      sync_q       <= '0;
      db_cnt_q     <= '0;
      level_q      <= '0;
      event_q      <= '0;
      state_q      <= StRun;
      mode_q       <= ModeManual;
      div_q        <= '0;
      ce_q         <= 1'b0;
      count_q      <= '0;
      halt_prev_q  <= 1'b0;
      limit_prev_q <= '0;
    end else begin
      sync_q       <= sync_d;
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      event_q      <= event_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      div_q        <= div_d;
      ce_q         <= ce_d;
      count_q      <= count_d;
      halt_prev_q  <= iHalt;
      limit_prev_q <= iLimit;
    end
  end

  assign oClockEnable = ce_q;
  assign oMode        = mode_q;
  assign oHalted      = (state_q == StHalted);
  assign oCycleCount  = count_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed testbench for clock_sequencer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2,
// SLOW_SHIFT=2, COUNT_WIDTH=4).
module tb_clock_sequencer;

  logic       iClock = 1'b0;
  logic       iReset;
  logic       iModeButton;
  logic       iStepButton;
  logic       iHalt;
  logic [7:0] iLimit;
  logic       oClockEnable;
  logic [1:0] oMode;
  logic       oHalted;
  logic [3:0] oCycleCount;

  int total = 0;
  int bad   = 0;

  // Per-window observation results.
  logic ce_hist [0:63];
  int   npulse;
  int   p1;
  int   p2;
  int   found;

  clock_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2),
    .SLOW_SHIFT     (2),
    .COUNT_WIDTH    (4)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iModeButton (iModeButton),
    .iStepButton (iStepButton),
    .iHalt       (iHalt),
    .iLimit      (iLimit),
    .oClockEnable(oClockEnable),
    .oMode       (oMode),
    .oHalted     (oHalted),
    .oCycleCount (oCycleCount)
  );

  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold buttons for 'hold' cycles then release; observe hold+12 cycles in total.
  // Tick k is the k-th rising edge after the buttons were driven.
  task automatic press(input logic m, input logic s, input int hold);
    npulse = 0; p1 = 0; p2 = 0;
    iModeButton = m;
    iStepButton = s;
    for (int k = 1; k <= hold + 12; k++) begin
      if (k == hold + 1) begin
        iModeButton = 1'b0;
        iStepButton = 1'b0;
      end
      tick();
      ce_hist[k] = oClockEnable;
      if (oClockEnable) begin
        npulse++;
        if (p1 == 0) p1 = k;
        else if (p2 == 0) p2 = k;
      end
    end
  endtask

  task automatic observe(input int n);
    npulse = 0; p1 = 0; p2 = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      ce_hist[k] = oClockEnable;
      if (oClockEnable) begin
        npulse++;
        if (p1 == 0) p1 = k;
        else if (p2 == 0) p2 = k;
      end
    end
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    tick();
    tick();
    iReset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    iReset = 1'b1; iModeButton = 1'b0; iStepButton = 1'b0; iHalt = 1'b0; iLimit = 8'd0;
    tick();
    tick();
    // 1. Reset values, single step pulse at tick 8, glitch rejected.
    check("rst_mode", 32'(oMode), 32'd0);
    check("rst_ce", 32'(oClockEnable), 32'd0);
    check("rst_halted", 32'(oHalted), 32'd0);
    check("rst_count", 32'(oCycleCount), 32'd0);
    iReset = 1'b0;
    tick();
    press(1'b0, 1'b1, 10);
    check("step_npulse", 32'(npulse), 32'd1);
    check("step_latency", 32'(p1), 32'd8);
    check("step_count", 32'(oCycleCount), 32'd1);
    press(1'b0, 1'b1, 3);
    check("glitch_npulse", 32'(npulse), 32'd0);
    check("glitch_count", 32'(oCycleCount), 32'd1);

    // 2. Mode cycling with wrap; no pulse on the change cycle.
    press(1'b1, 1'b0, 10);
    check("mode_01", 32'(oMode), 32'd1);
    press(1'b1, 1'b0, 10);
    check("mode_10", 32'(oMode), 32'd2);
    press(1'b1, 1'b0, 10);
    check("mode_11", 32'(oMode), 32'd3);
    check("fast_before_chg", 32'(ce_hist[7]), 32'd1);
    check("fast_to_max_chg", 32'(ce_hist[8]), 32'd0);
    check("max_after_chg", 32'(ce_hist[9]), 32'd1);
    press(1'b1, 1'b0, 10);
    check("mode_wrap_00", 32'(oMode), 32'd0);
    check("max_before_chg", 32'(ce_hist[7]), 32'd1);
    check("max_to_man_chg", 32'(ce_hist[8]), 32'd0);
    check("manual_after_chg", 32'(ce_hist[9]), 32'd0);

    // 3. FAST with iLimit=3, SLOW with iLimit=1, then iLimit change mid-period.
    iLimit = 8'd3;
    do_reset();
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    check("fast_mode", 32'(oMode), 32'd2);
    observe(20);
    check("fast_npulse", 32'(npulse), 32'd5);
    check("fast_gap", 32'(p2 - p1), 32'd4);
    iLimit = 8'd1;
    do_reset();
    press(1'b1, 1'b0, 10);
    check("slow_mode", 32'(oMode), 32'd1);
    observe(40);
    check("slow_npulse", 32'(npulse), 32'd5);
    check("slow_gap", 32'(p2 - p1), 32'd8);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick();
      if (oClockEnable) found = 1;
    end
    check("slow_pulse_found", 32'(found), 32'd1);
    tick();
    tick();
    tick();
    iLimit = 8'd2;
    observe(20);
    check("limit_chg_next", 32'(p1), 32'd13);
    check("limit_chg_npulse", 32'(npulse), 32'd1);

    // 4. Halt in MAX, single steps, resume with mode press.
    iLimit = 8'd0;
    do_reset();
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    check("max_mode", 32'(oMode), 32'd3);
    check("max_running", 32'(oClockEnable), 32'd1);
    iHalt = 1'b1;
    tick();
    check("halt_state", 32'(oHalted), 32'd1);
    check("halt_no_pulse", 32'(oClockEnable), 32'd0);
    observe(5);
    check("halted_idle", 32'(npulse), 32'd0);
    press(1'b0, 1'b1, 10);
    check("halt_step1", 32'(npulse), 32'd1);
    press(1'b0, 1'b1, 10);
    check("halt_step2", 32'(npulse), 32'd1);
    check("halt_still", 32'(oHalted), 32'd1);
    press(1'b1, 1'b0, 10);
    check("resume_halted", 32'(oHalted), 32'd0);
    check("resume_mode", 32'(oMode), 32'd3);
    check("resume_chg_cycle", 32'(ce_hist[8]), 32'd0);
    check("resume_npulse", 32'(npulse), 32'd14);

    // 5. Simultaneous mode and step events while halted (MANUAL mode).
    press(1'b1, 1'b0, 10);
    check("held_halt_no_rehalt", 32'(oHalted), 32'd0);
    check("to_manual", 32'(oMode), 32'd0);
    iHalt = 1'b0;
    tick();
    iHalt = 1'b1;
    tick();
    check("halt_again", 32'(oHalted), 32'd1);
    press(1'b1, 1'b1, 10);
    check("both_exit", 32'(oHalted), 32'd0);
    check("both_no_step", 32'(npulse), 32'd0);
    check("both_mode_kept", 32'(oMode), 32'd0);

    // 6. Count saturation in MAX, then reset mid-run.
    iHalt = 1'b0;
    do_reset();
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    check("sat_count", 32'(oCycleCount), 32'hF);
    observe(5);
    check("sat_npulse", 32'(npulse), 32'd5);
    check("sat_hold", 32'(oCycleCount), 32'hF);
    iReset = 1'b1;
    tick();
    check("midrst_mode", 32'(oMode), 32'd0);
    check("midrst_ce", 32'(oClockEnable), 32'd0);
    check("midrst_halted", 32'(oHalted), 32'd0);
    check("midrst_count", 32'(oCycleCount), 32'd0);
    iReset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
